ctrl_seq: RTL and testbench

Parametrised instruction sequencer, next generation of the core control FSM. Fetches, decodes and executes 1–2 word instructions and drives the datapath control lines (memory, address register, ALU, register file, bus mux). Over the previous controller it adds:
- parametrised data and register-select widths
- a hardware call/return stack
- a single maskable interrupt with vector entry
- a memory-wait timeout with a sticky fault.

---
 rtl/ctrl_seq.sv | 205 ++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// Instruction sequencer: fetch/decode/execute of 1-2 word instructions with a
// return stack, one maskable vectored interrupt and a memory-wait timeout.
module ctrl_seq #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_SEL_WIDTH  = 2,
  parameter int STACK_DEPTH    = 4,
  parameter int MEM_TIMEOUT    = 15,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = ADDR_WIDTH'('hF0)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [DATA_BUS_WIDTH-1:0] i_bus_data_in,
  input  logic                      i_mem_op_done,
  input  logic                      i_flag_carry_in,
  input  logic                      i_flag_zero_in,
  input  logic [ADDR_WIDTH-1:0]     i_pc_value,
  input  logic                      i_irq,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic                      o_addr_sel,
  output logic [2:0]                o_pc_op,
  output logic                      o_pc_load,
  output logic [ADDR_WIDTH-1:0]     o_pc_load_value,
  output logic [3:0]                o_alu_op,
  output logic                      o_reg_we,
  output logic [REG_SEL_WIDTH-1:0]  o_reg_sel_in,
  output logic [REG_SEL_WIDTH-1:0]  o_reg_sel_1,
  output logic [REG_SEL_WIDTH-1:0]  o_reg_sel_2,
  output logic [1:0]                o_mux_sel,
  output logic                      o_irq_ack,
  output logic                      o_fault
);
  localparam int DW  = DATA_BUS_WIDTH;
  localparam int AW  = ADDR_WIDTH;
  localparam int RW  = REG_SEL_WIDTH;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int TW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0] PC_NOP = 3'd0, PC_INC = 3'd1;
  localparam logic [1:0] MUX_ALU = 2'd0, MUX_MEM = 2'd1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_PARAM, S_MEM_WAIT, S_INC_PC, S_IRQ_ENTRY, S_FAULT
  } state_t;
  typedef enum logic [1:0] {K_ALU, K_CALL, K_JMP} kind_t;

  state_t               r_state;
  kind_t                r_kind;
  logic [AW-1:0]        r_stack [STACK_DEPTH];
  logic [SPW-1:0]       r_sp;
  logic [TW-1:0]        r_tmo;
  logic                 r_ie, r_in_isr, r_carry, r_zero, r_ldx_wr;
  logic                 r_mem_req, r_mem_we, r_addr_sel, r_pc_load, r_reg_we, r_irq_ack, r_fault;
  logic [2:0]           r_pc_op;
  logic [AW-1:0]        r_pc_load_value;
  logic [3:0]           r_alu_op;
  logic [RW-1:0]        r_reg_sel_in, r_reg_sel_1, r_reg_sel_2;
  logic [1:0]           r_mux_sel;

  logic [1:0]    w_op, w_sub;
  logic          w_b5, w_b6, w_full, w_empty, w_wait, w_tmo_hit, w_stk_fault, w_jmp_take, w_irq_go;
  logic [IW-1:0] w_push_idx, w_pop_idx;

  assign w_op       = i_bus_data_in[DW-1 -: 2];
  assign w_sub      = i_bus_data_in[DW-3 -: 2];
  assign w_b5       = i_bus_data_in[DW-5];
  assign w_b6       = i_bus_data_in[DW-6];
  assign w_full     = (r_sp == SPW'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = r_sp[IW-1:0];
  assign w_pop_idx  = IW'(r_sp - 1'b1);
  assign w_wait     = (r_state == S_DECODE) || (r_state == S_PARAM) || (r_state == S_MEM_WAIT);
  assign w_tmo_hit  = w_wait && !i_mem_op_done && (r_tmo == TW'(MEM_TIMEOUT - 1));
  // Stack never wraps: underflow on RET/RETI and overflow on CALL both trap.
  assign w_stk_fault = i_mem_op_done &&
      (((r_state == S_DECODE) && (w_op == 2'b00) && (w_sub == 2'b10) && w_empty) ||
       ((r_state == S_PARAM) && (r_kind == K_CALL) && w_full));
  assign w_jmp_take = (w_sub == 2'b00) | (w_sub[1] & r_carry) | (w_sub[0] & r_zero);
  assign w_irq_go   = i_irq & r_ie & ~r_in_isr & ~w_full;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_FETCH;  r_kind <= K_ALU;  r_sp <= '0;  r_tmo <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
      r_ie <= 1'b0;  r_in_isr <= 1'b0;  r_carry <= 1'b0;  r_zero <= 1'b0;  r_ldx_wr <= 1'b0;
      r_mem_req <= 1'b0;  r_mem_we <= 1'b0;  r_addr_sel <= 1'b0;  r_pc_op <= PC_NOP;
      r_pc_load <= 1'b0;  r_pc_load_value <= '0;  r_alu_op <= '0;  r_reg_we <= 1'b0;
      r_reg_sel_in <= '0;  r_reg_sel_1 <= '0;  r_reg_sel_2 <= '0;  r_mux_sel <= MUX_ALU;
      r_irq_ack <= 1'b0;  r_fault <= 1'b0;
    end else begin
      r_pc_op <= PC_NOP;  r_pc_load <= 1'b0;  r_reg_we <= 1'b0;  r_irq_ack <= 1'b0;
      r_mem_req <= 1'b0;  r_mem_we <= 1'b0;  r_addr_sel <= 1'b0;  r_mux_sel <= MUX_ALU;
      r_tmo <= '0;
      if (r_state == S_FAULT || w_tmo_hit || w_stk_fault) begin
        r_state <= S_FAULT;  r_fault <= 1'b1;  r_pc_load_value <= '0;  r_alu_op <= '0;
        r_reg_sel_in <= '0;  r_reg_sel_1 <= '0;  r_reg_sel_2 <= '0;
      end else begin
        case (r_state)
          S_FETCH: begin
            r_mem_req <= 1'b1;  r_mux_sel <= MUX_MEM;  r_state <= S_DECODE;
          end
          S_DECODE: begin
            if (!i_mem_op_done) begin
              r_mem_req <= 1'b1;  r_mux_sel <= MUX_MEM;  r_tmo <= r_tmo + 1'b1;
            end else begin
              case (w_op)
                2'b00: begin
                  case (w_sub)
                    2'b00: r_state <= S_INC_PC;
                    2'b01: begin
                      r_kind <= K_CALL;  r_pc_op <= PC_INC;  r_mem_req <= 1'b1;
                      r_mux_sel <= MUX_MEM;  r_state <= S_PARAM;
                    end
                    2'b10: begin
                      r_sp <= r_sp - 1'b1;  r_pc_load <= 1'b1;
                      r_pc_load_value <= r_stack[w_pop_idx];
                      if (w_b5) r_in_isr <= 1'b0;
                      r_state <= S_FETCH;
                    end
                    default: begin
                      if (w_b5) r_ie <= w_b6;
                      r_state <= S_INC_PC;
                    end
                  endcase
                end
                2'b01: begin
                  r_alu_op <= i_bus_data_in[DW-3 -: 4];  r_reg_sel_1 <= i_bus_data_in[RW-1:0];
                  r_kind <= K_ALU;  r_pc_op <= PC_INC;  r_mem_req <= 1'b1;
                  r_mux_sel <= MUX_MEM;  r_state <= S_PARAM;
                end
                2'b10: begin
                  if (w_sub[1] == 1'b0) begin
                    r_ldx_wr <= w_sub[0];  r_mem_req <= 1'b1;  r_mem_we <= w_sub[0];
                    r_addr_sel <= 1'b1;  r_state <= S_MEM_WAIT;
                    if (w_sub[0]) r_reg_sel_1 <= i_bus_data_in[DW-5 -: RW];
                    else begin
                      r_reg_sel_in <= i_bus_data_in[DW-5 -: RW];  r_mux_sel <= MUX_MEM;
                    end
                  end else r_state <= S_INC_PC;
                end
                default: begin
                  r_pc_op <= PC_INC;
                  if (w_jmp_take) begin
                    r_kind <= K_JMP;  r_mem_req <= 1'b1;  r_mux_sel <= MUX_MEM;  r_state <= S_PARAM;
                  end else r_state <= S_INC_PC;
                end
              endcase
            end
          end
          S_PARAM: begin
            if (!i_mem_op_done) begin
              r_mem_req <= 1'b1;  r_mux_sel <= MUX_MEM;  r_tmo <= r_tmo + 1'b1;
            end else begin
              case (r_kind)
                K_ALU: begin
                  r_reg_sel_2 <= i_bus_data_in[DW-1 -: RW];
                  r_reg_sel_in <= i_bus_data_in[DW-1-RW -: RW];
                  r_reg_we <= 1'b1;  r_carry <= i_flag_carry_in;  r_zero <= i_flag_zero_in;
                  r_state <= S_INC_PC;
                end
                K_CALL: begin
                  r_stack[w_push_idx] <= i_pc_value + 1'b1;  r_sp <= r_sp + 1'b1;
                  r_pc_load <= 1'b1;  r_pc_load_value <= AW'(i_bus_data_in);  r_state <= S_FETCH;
                end
                default: begin
                  r_pc_load <= 1'b1;  r_pc_load_value <= AW'(i_bus_data_in);  r_state <= S_FETCH;
                end
              endcase
            end
          end
          S_MEM_WAIT: begin
            if (!i_mem_op_done) begin
              r_mem_req <= 1'b1;  r_mem_we <= r_ldx_wr;  r_addr_sel <= 1'b1;
              r_mux_sel <= r_ldx_wr ? MUX_ALU : MUX_MEM;  r_tmo <= r_tmo + 1'b1;
            end else begin
              if (!r_ldx_wr) begin
                r_reg_we <= 1'b1;  r_mux_sel <= MUX_MEM;
              end
              r_state <= S_INC_PC;
            end
          end
          S_INC_PC: begin
            r_pc_op <= PC_INC;
            r_state <= w_irq_go ? S_IRQ_ENTRY : S_FETCH;
          end
          S_IRQ_ENTRY: begin
            r_stack[w_push_idx] <= i_pc_value;  r_sp <= r_sp + 1'b1;
            r_pc_load <= 1'b1;  r_pc_load_value <= IRQ_VECTOR;  r_irq_ack <= 1'b1;
            r_in_isr <= 1'b1;  r_state <= S_FETCH;
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign o_mem_req = r_mem_req;      assign o_mem_we = r_mem_we;
  assign o_addr_sel = r_addr_sel;    assign o_pc_op = r_pc_op;
  assign o_pc_load = r_pc_load;      assign o_pc_load_value = r_pc_load_value;
  assign o_alu_op = r_alu_op;        assign o_reg_we = r_reg_we;
  assign o_reg_sel_in = r_reg_sel_in; assign o_reg_sel_1 = r_reg_sel_1;
  assign o_reg_sel_2 = r_reg_sel_2;  assign o_mux_sel = r_mux_sel;
  assign o_irq_ack = r_irq_ack;      assign o_fault = r_fault;
endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: an instruction-memory responder feeds words,
// a scoreboard holds expected pc_load / reg_we / irq_ack events.
module tb_ctrl_seq;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] bus_data_in = '0;
  logic       mem_op_done = 1'b0, flag_carry_in = 1'b0, flag_zero_in = 1'b0, irq = 1'b0;
  logic [7:0] pc_value = '0;
  logic       mem_req, mem_we, addr_sel, pc_load, reg_we, irq_ack, fault;
  logic [2:0] pc_op;
  logic [7:0] pc_load_value;
  logic [3:0] alu_op;
  logic [1:0] reg_sel_in, reg_sel_1, reg_sel_2, mux_sel;

  typedef struct packed {
    logic [1:0] mux; logic [1:0] sel_in; logic [1:0] sel1; logic [1:0] sel2;
    logic [3:0] alu; logic chk_alu;
  } we_t;

  logic [7:0] q_mem[$];
  logic [7:0] q_load[$];
  we_t        q_we[$];
  int         exp_ack = 0;
  logic       ram_hang = 1'b0;
  int         checks = 0, failures = 0;

  ctrl_seq dut (
    .i_clock(clk), .i_reset(rst), .i_bus_data_in(bus_data_in), .i_mem_op_done(mem_op_done),
    .i_flag_carry_in(flag_carry_in), .i_flag_zero_in(flag_zero_in), .i_pc_value(pc_value),
    .i_irq(irq), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_addr_sel(addr_sel),
    .o_pc_op(pc_op), .o_pc_load(pc_load), .o_pc_load_value(pc_load_value), .o_alu_op(alu_op),
    .o_reg_we(reg_we), .o_reg_sel_in(reg_sel_in), .o_reg_sel_1(reg_sel_1),
    .o_reg_sel_2(reg_sel_2), .o_mux_sel(mux_sel), .o_irq_ack(irq_ack), .o_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction memory answers every request in the same cycle; NOP when idle.
  always @(negedge clk) begin
    if (mem_req && !rst) begin
      if (addr_sel) begin
        mem_op_done = !ram_hang;
        bus_data_in = 8'h5A;
      end else begin
        mem_op_done = 1'b1;
        bus_data_in = (q_mem.size() > 0) ? q_mem.pop_front() : 8'h00;
      end
    end else mem_op_done = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pc_load) begin
        chk("pc_load_expected", q_load.size() > 0, 1);
        if (q_load.size() > 0) chk("pc_load_value", pc_load_value, q_load.pop_front());
      end
      if (irq_ack) begin
        chk("irq_ack_expected", exp_ack > 0, 1);
        if (exp_ack > 0) exp_ack--;
      end
      if (reg_we) begin
        chk("reg_we_expected", q_we.size() > 0, 1);
        if (q_we.size() > 0) begin
          we_t e;
          e = q_we.pop_front();
          chk("we_mux_sel", mux_sel, e.mux);
          chk("we_reg_sel_in", reg_sel_in, e.sel_in);
          if (e.chk_alu) begin
            chk("we_alu_op", alu_op, e.alu);
            chk("we_reg_sel_1", reg_sel_1, e.sel1);
            chk("we_reg_sel_2", reg_sel_2, e.sel2);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;  irq = 1'b0;  ram_hang = 1'b0;
    q_mem.delete();  q_load.delete();  q_we.delete();  exp_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int extra);
    for (int i = 0; i < 300 && q_mem.size() > 0; i++) @(posedge clk);
    chk("mem_drained", q_mem.size(), 0);
    repeat (extra) @(posedge clk);
    #1;
    chk("loads_left", q_load.size(), 0);
    chk("we_left", q_we.size(), 0);
    chk("acks_left", exp_ack, 0);
  endtask

  task automatic wait_ldx();
    for (int i = 0; i < 20 && !addr_sel; i++) begin
      @(posedge clk);
      #1;
    end
    chk("ldx_wait_entered", addr_sel, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    #12;
    chk("rst_mem_req", mem_req, 0);  chk("rst_pc_op", pc_op, 0);
    chk("rst_fault", fault, 0);      chk("rst_pc_load_value", pc_load_value, 0);
    do_reset();
    // NOP timing from reset
    @(posedge clk); #1;
    chk("c1_mem_req", mem_req, 1);  chk("c1_mux_sel", mux_sel, 1);  chk("c1_addr_sel", addr_sel, 0);
    @(posedge clk); #1;
    chk("c2_pc_op", pc_op, 0);      chk("c2_mem_req", mem_req, 0);
    @(posedge clk); #1;
    chk("c3_pc_op", pc_op, 1);
    @(posedge clk); #1;
    chk("c4_mem_req", mem_req, 1);  chk("c4_pc_op", pc_op, 0);  chk("c4_fault", fault, 0);

    // ALU then JMP on latched carry
    flag_carry_in = 1'b1;  flag_zero_in = 1'b0;
    q_mem.push_back(8'h46);  q_mem.push_back(8'h90);
    q_we.push_back('{mux: 2'd0, sel_in: 2'd1, sel1: 2'd2, sel2: 2'd2, alu: 4'd1, chk_alu: 1'b1});
    drain(6);
    flag_carry_in = 1'b0;
    q_mem.push_back(8'hE0);  q_mem.push_back(8'h33);  q_load.push_back(8'h33);
    drain(6);
    // JMP on zero (zero latched 0) not taken: next word is an instruction, not a param
    q_mem.push_back(8'hD0);  q_mem.push_back(8'h00);
    drain(6);
    q_mem.push_back(8'hC0);  q_mem.push_back(8'h77);  q_load.push_back(8'h77);
    drain(6);

    // CALL / RET
    pc_value = 8'h05;
    q_mem.push_back(8'h10);  q_mem.push_back(8'h40);  q_mem.push_back(8'h20);
    q_load.push_back(8'h40);  q_load.push_back(8'h06);
    drain(6);

    // LDX read, write, and undefined sub
    q_mem.push_back(8'h84);
    q_we.push_back('{mux: 2'd1, sel_in: 2'd1, sel1: 2'd0, sel2: 2'd0, alu: 4'd0, chk_alu: 1'b0});
    q_mem.push_back(8'h94);  q_mem.push_back(8'hA0);
    drain(8);
    chk("no_fault_after_ldx", fault, 0);

    // stack overflow on 5th nested CALL
    do_reset();
    for (int i = 0; i < 5; i++) begin
      q_mem.push_back(8'h10);  q_mem.push_back(8'h41 + 8'(i));
      if (i < 4) q_load.push_back(8'h41 + 8'(i));
    end
    drain(4);
    chk("ovf_fault", fault, 1);  chk("ovf_mem_req", mem_req, 0);
    chk("ovf_pc_load_value", pc_load_value, 0);  chk("ovf_pc_op", pc_op, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_fault_sticky", fault, 1);

    // RET on empty stack
    do_reset();
    q_mem.push_back(8'h20);
    drain(4);
    chk("unf_fault", fault, 1);

    // interrupt entry, ignored while in ISR, RETI, re-entry
    do_reset();
    pc_value = 8'h05;  irq = 1'b1;
    q_mem.push_back(8'h3C);  q_load.push_back(8'hF0);  exp_ack = 1;
    drain(14);
    irq = 1'b0;
    q_mem.push_back(8'h28);  q_load.push_back(8'h05);
    drain(6);
    irq = 1'b1;  q_load.push_back(8'hF0);  exp_ack = 1;
    drain(10);
    irq = 1'b0;
    chk("irq_no_fault", fault, 0);

    // memory-wait timeout
    do_reset();
    ram_hang = 1'b1;
    q_mem.push_back(8'h80);
    wait_ldx();
    n = 0;
    for (int i = 0; i < 40 && !fault; i++) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("timeout_cycles", n, 15);
    chk("timeout_addr_sel", addr_sel, 0);

    // asynchronous reset mid-wait
    do_reset();
    ram_hang = 1'b1;
    q_mem.push_back(8'h80);
    wait_ldx();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 0);  chk("arst_addr_sel", addr_sel, 0);
    chk("arst_mux_sel", mux_sel, 0);  chk("arst_fault", fault, 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
